// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: pops line-terminated ASCII commands from the UART RX FIFO, drives LED/RGB, queues 4-byte replies.
module uart_cmd_parser #(
  parameter logic [7:0] TERM_CR = 8'h0D,
  parameter logic [7:0] TERM_LF = 8'h0A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart,
  output logic [3:0] led,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b
);
  typedef enum logic [2:0] {IDLE, ARG, TERM, DISCARD, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [1:0] op;
  logic [3:0] arg;
  logic [1:0] idx;
  logic       last;
  logic [7:0] b0, b1;
  logic       is_term, hex_ok, oct_ok, arg_ok, push, load_err;
  logic [3:0] hex_val;
  always_comb begin
    is_term  = r_data == TERM_CR || r_data == TERM_LF;
    hex_ok   = (r_data >= "0" && r_data <= "9") || (r_data >= "A" && r_data <= "F") || (r_data >= "a" && r_data <= "f");
    hex_val  = r_data <= "9" ? r_data[3:0] : r_data[3:0] + 4'd9;
    oct_ok   = r_data >= "0" && r_data <= "7";
    arg_ok   = op == 2'd1 ? oct_ok : hex_ok;
    rd_uart  = !rx_empty && (state == IDLE || state == ARG || state == TERM || state == DISCARD);
    push     = state == RESP && !tx_full && !last;
    state_n  = state;
    case (state)
      IDLE:    if (rd_uart) state_n = is_term ? IDLE : (r_data == "L" || r_data == "C") ? ARG : r_data == "?" ? TERM : DISCARD;
      ARG:     if (rd_uart) state_n = arg_ok ? TERM : is_term ? RESP : DISCARD;
      TERM:    if (rd_uart) state_n = is_term ? EXEC : DISCARD;
      DISCARD: if (rd_uart && is_term) state_n = RESP;
      EXEC:    state_n = RESP;
      RESP:    if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    load_err = state_n == RESP && (state == ARG || state == DISCARD);
  end
  // last holds the FSM in RESP one extra cycle so the final registered push never overlaps a pop
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op      <= '0;
      arg     <= '0;
      idx     <= '0;
      last    <= 1'b0;
      b0      <= '0;
      b1      <= '0;
      w_data  <= '0;
      wr_uart <= 1'b0;
      led     <= '0;
      {led_r, led_g, led_b} <= '0;
    end else begin
      state   <= state_n;
      wr_uart <= push;
      if (push) begin
        w_data <= idx == 2'd0 ? b0 : idx == 2'd1 ? b1 : idx == 2'd2 ? 8'h0D : 8'h0A;
        idx    <= idx == 2'd3 ? idx : idx + 2'd1;
        last   <= idx == 2'd3;
      end
      if (state == IDLE && rd_uart) op <= r_data == "C" ? 2'd1 : r_data == "?" ? 2'd2 : 2'd0;
      if (state == ARG && rd_uart) arg <= op == 2'd1 ? {1'b0, r_data[2:0]} : hex_val;
      if (state == TERM && rd_uart && is_term && op == 2'd0) led <= arg;
      if (state == TERM && rd_uart && is_term && op == 2'd1) {led_r, led_g, led_b} <= arg[2:0];
      if (state == EXEC) begin
        b0   <= op == 2'd2 ? (led < 4'd10 ? {4'h3, led} : 8'h37 + {4'h0, led}) : "O";
        b1   <= op == 2'd2 ? 8'h30 + {5'b0, led_r, led_g, led_b} : "K";
        idx  <= '0;
        last <= 1'b0;
      end
      if (load_err) begin
        b0   <= "E";
        b1   <= "R";
        idx  <= '0;
        last <= 1'b0;
      end
    end
  end
endmodule
